// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
//   spi_slave_state_e : responder FSM states
//   SPI_DATA_WIDTH    : default word size
//   SPI_MODE0..3      : {CPOL,CPHA} mode encodings
package spi_pkg;

  localparam int unsigned SPI_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_slave_state_e;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for an asynchronous SPI pin.
//   clk, reset : system clock, async active-high reset
//   d          : asynchronous input pin
//   q          : synchronized output (resets to RESET_VAL)
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= {SYNC_STAGES{RESET_VAL}};
    else       chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI responder, all four CPOL/CPHA modes, MSB first, oversampled in clk.
//   clk, reset        : system clock, async active-high reset
//   CPOL, CPHA        : SPI mode, static while selected
//   tx_data, tx_load  : write one-byte transmit buffer (only when tx_ready)
//   tx_ready          : transmit buffer empty
//   rx_data, rx_valid : last received byte, one-clk update pulse
//   tx_underrun       : pulse when an empty buffer is consumed
//   busy              : transfer in progress
//   SCLK, SS_n, MOSI  : SPI pins from master
//   MISO, miso_oe     : SPI data out and its output enable
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy,
  input  logic                  SCLK,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  miso_oe
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);

  spi_slave_state_e      state;
  logic                  sclk_s, sclk_d, ss_s, ss_d, mosi_s;
  logic [DATA_WIDTH-1:0] tx_buf, tx_shift, buf_out;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [CW-1:0]         bit_cnt;
  logic                  first;
  logic                  ss_fall, ss_rise, lead, trail;
  logic                  sample_edge, shift_edge, reload, load_ok, last_bit;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(SCLK), .q(sclk_s));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .d(SS_n), .q(ss_s));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(MOSI), .q(mosi_s));

  assign ss_fall  = ss_d & ~ss_s;
  assign ss_rise  = ~ss_d & ss_s;
  assign lead     = (sclk_s != CPOL) && (sclk_d == CPOL);
  assign trail    = (sclk_s == CPOL) && (sclk_d != CPOL);
  assign last_bit = (bit_cnt == CW'(DATA_WIDTH - 1));

  // Deselect wins over any SCLK edge detected in the same cycle.
  assign sample_edge = (state == SHIFT) && !ss_rise && (CPHA ? trail : lead);
  assign shift_edge  = (state == SHIFT) && !ss_rise && (CPHA ? lead : trail);

  // Buffer is consumed on select and at every byte boundary shift edge,
  // except the very first CPHA=1 leading edge where bit 7 is already out.
  assign reload  = ((state == IDLE) && ss_fall) ||
                   (shift_edge && (bit_cnt == '0) && !first);
  assign load_ok = tx_load & tx_ready;
  assign buf_out = tx_ready ? '0 : tx_buf;

  assign busy = (state == SHIFT);
  assign MISO = tx_shift[DATA_WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sclk_d      <= 1'b0;
      ss_d        <= 1'b1;
      tx_buf      <= '0;
      tx_ready    <= 1'b1;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      bit_cnt     <= '0;
      first       <= 1'b0;
      miso_oe     <= 1'b0;
    end else begin
      sclk_d      <= sclk_s;
      ss_d        <= ss_s;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      // A load in the same cycle as a consume: the consume already saw the
      // old empty buffer, so the new byte is kept and the buffer stays full.
      if (load_ok) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end else if (reload) begin
        tx_ready <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state       <= SHIFT;
            tx_shift    <= buf_out;
            tx_underrun <= tx_ready;
            bit_cnt     <= '0;
            first       <= 1'b1;
            miso_oe     <= 1'b1;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
            miso_oe <= 1'b0;
          end else if (sample_edge) begin
            rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi_s};
            if (last_bit) begin
              rx_data  <= {rx_shift, mosi_s};
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (shift_edge) begin
            first <= 1'b0;
            if (bit_cnt == '0) begin
              if (!first) begin
                tx_shift    <= buf_out;
                tx_underrun <= tx_ready;
              end
            end else begin
              tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bit-banged SPI master, scoreboard for
// received bytes, transaction-level model of the transmit buffer.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int H = 10; // SCLK half-period in clk cycles

  logic       clk = 1'b0;
  logic       reset, CPOL, CPHA, tx_load, SCLK, SS_n, MOSI;
  logic [7:0] tx_data, rx_data;
  logic       tx_ready, rx_valid, tx_underrun, busy, MISO, miso_oe;

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .CPOL(CPOL), .CPHA(CPHA),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .busy(busy), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .miso_oe(miso_oe));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int rx_seen = 0;
  int underrun_seen = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] model_last_rx;
  logic [7:0] mo_q[$];
  logic [7:0] sl_q[$];
  bit         have_q[$];
  bit         refill_pending;
  logic [7:0] refill_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rx_valid must match the oldest expected byte.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (rx_valid === 1'b1) begin
        rx_seen++;
        if (exp_rx_q.size() == 0) check("rx_unexpected", 1, 0);
        else check("rx_data", rx_data, exp_rx_q.pop_front());
      end
      if (tx_underrun === 1'b1) underrun_seen++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // One SCLK half-period; local refill logic reacts to rx_valid here.
  task automatic half_wait();
    for (int k = 0; k < H; k++) begin
      @(negedge clk);
      tx_load = 1'b0;
      if (refill_pending && rx_valid === 1'b1) begin
        tx_data = refill_byte;
        tx_load = 1'b1;
        refill_pending = 1'b0;
      end
    end
    if (tx_load) begin
      @(negedge clk);
      tx_load = 1'b0;
    end
  endtask

  task automatic add_byte(input logic [7:0] m, input logic [7:0] s, input bit h);
    mo_q.push_back(m);
    sl_q.push_back(s);
    have_q.push_back(h);
  endtask

  // Runs one SS_n transaction from mo_q/sl_q/have_q; abort_bits>0 deselects
  // after that many sample edges.
  task automatic xfer(input logic [1:0] mode, input int abort_bits);
    int n, total, completed, started, slots, exp_u, u0, r0;
    logic [7:0] cur;
    logic [7:0] got[$];
    n     = mo_q.size();
    total = (abort_bits > 0) ? abort_bits : n * 8;
    completed = total / 8;
    started   = (total + 7) / 8;
    CPOL = mode[1];
    CPHA = mode[0];
    SCLK = mode[1];
    MOSI = 1'b0;
    cur  = '0;
    repeat (8) @(negedge clk);
    check("oe_idle", miso_oe, 0);
    if (have_q[0]) begin
      tx_data = sl_q[0];
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      check("tx_ready_after_load", tx_ready, 0);
    end
    u0 = underrun_seen;
    r0 = rx_seen;
    SS_n = 1'b0;
    half_wait();
    check("tx_ready_after_ss", tx_ready, 1);
    check("oe_selected", miso_oe, 1);
    check("busy_selected", busy, 1);
    for (int b = 0; b < total; b++) begin
      int i, j;
      i = b / 8;
      j = 7 - (b % 8);
      if (b % 8 == 0) begin
        if (b + 8 <= total) begin
          exp_rx_q.push_back(mo_q[i]);
          model_last_rx = mo_q[i];
        end
        if (i + 1 < n && have_q[i+1]) begin
          refill_pending = 1'b1;
          refill_byte    = sl_q[i+1];
        end
      end
      if (CPHA == 1'b0) begin
        MOSI = mo_q[i][j];
        SCLK = ~CPOL;
        cur  = {cur[6:0], MISO};
        half_wait();
        SCLK = CPOL;
        half_wait();
      end else begin
        SCLK = ~CPOL;
        MOSI = mo_q[i][j];
        half_wait();
        SCLK = CPOL;
        cur  = {cur[6:0], MISO};
        half_wait();
      end
      if (b % 8 == 7) got.push_back(cur);
    end
    SS_n = 1'b1;
    refill_pending = 1'b0;
    half_wait();
    check("oe_deselected", miso_oe, 0);
    check("busy_deselected", busy, 0);
    for (int i = 0; i < got.size(); i++)
      check("master_rx", got[i], have_q[i] ? sl_q[i] : 8'h00);
    // Buffer consumed at select and at each byte boundary shift edge; with
    // CPHA=0 the edge after the last completed byte also consumes.
    slots = (CPHA == 1'b0) ? completed + 1 : ((started > 0) ? started : 1);
    exp_u = 0;
    for (int s = 0; s < slots; s++)
      if (s >= n || !have_q[s]) exp_u++;
    check("underruns", underrun_seen - u0, exp_u);
    check("rx_pulses", rx_seen - r0, completed);
    check("rx_hold", rx_data, model_last_rx);
    mo_q.delete();
    sl_q.delete();
    have_q.delete();
  endtask

  initial begin
    reset = 1'b1; CPOL = 1'b0; CPHA = 1'b0; tx_load = 1'b0; tx_data = '0;
    SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0; refill_pending = 1'b0;
    refill_byte = '0; model_last_rx = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_underrun", tx_underrun, 0);
    check("rst_busy", busy, 0);
    check("rst_miso", MISO, 0);
    check("rst_oe", miso_oe, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    add_byte(8'hA5, 8'h3C, 1);
    xfer(SPI_MODE0, 0);
    add_byte(8'h5A, 8'hC3, 1);
    xfer(SPI_MODE3, 0);
    add_byte(8'h12, 8'hAB, 1); add_byte(8'h34, 8'hCD, 1);
    xfer(SPI_MODE1, 0);
    add_byte(8'h12, 8'hAB, 1); add_byte(8'h34, 8'hCD, 1);
    xfer(SPI_MODE2, 0);
    add_byte(8'h96, 8'h00, 0);
    xfer(SPI_MODE0, 0);
    add_byte(8'hF0, 8'h00, 0);
    xfer(SPI_MODE0, 4);
    add_byte(8'hFF, 8'h55, 1);
    xfer(SPI_MODE0, 0);

    // Reset in the middle of a byte.
    CPOL = 1'b0; CPHA = 1'b0; SCLK = 1'b0;
    tx_data = 8'h77; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    SS_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      MOSI = 1'b1; SCLK = 1'b1;
      repeat (H) @(negedge clk);
      SCLK = 1'b0;
      repeat (H) @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_miso", MISO, 0);
    check("mid_rst_oe", miso_oe, 0);
    check("mid_rst_underrun", tx_underrun, 0);
    SS_n = 1'b1; MOSI = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_last_rx = 8'h00;
    repeat (3) @(negedge clk);
    add_byte(8'h81, 8'h18, 1);
    xfer(SPI_MODE0, 0);

    // Randomized transfers.
    for (int t = 0; t < 20; t++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int i = 0; i < nb; i++)
        add_byte(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      xfer(2'($urandom_range(0, 3)), 0);
    end

    repeat (5) @(negedge clk);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
